// File: rtl/pwm_fan_driver_pkg.sv
// Shared definitions for the fan PWM driver: FSM state encoding and the
// PWM period / full-scale constant derived from the duty width.
package pwm_fan_driver_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_KICK = 2'd1,
    ST_RUN  = 2'd2
  } fan_state_t;

  // PWM period in counter ticks; it also equals the full-scale duty value.
  function automatic int unsigned pwm_period(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_fan_driver_timebase.sv
// PWM timebase: clock prescaler, PWM counter over 0..P-1 and the period
// divider that paces the PID core's clock-enable strobe.
module pwm_timebase
  import pwm_fan_driver_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 4,
  parameter int PID_DIV  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic             o_wrap,
  output logic             o_pid_stb,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int unsigned P     = pwm_period(CNT_W);
  localparam int          PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int          DIV_W = (PID_DIV > 1) ? $clog2(PID_DIV) : 1;

  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_per;
  logic             r_pid_stb;
  logic             w_tick;
  logic             w_wrap;
  logic             w_div_last;

  assign w_tick     = i_en && (r_pre == PRE_W'(PRESCALE - 1));
  assign w_wrap     = w_tick && (r_cnt == CNT_W'(P - 1));
  assign w_div_last = (r_per == DIV_W'(PID_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_pre     <= '0;
      r_cnt     <= '0;
      r_per     <= '0;
      r_pid_stb <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_per <= w_div_last ? '0 : r_per + 1'b1;
      // Registered so the strobe is a clean single cycle after the wrap edge.
      r_pid_stb <= w_wrap && w_div_last;
    end
  end

  assign o_wrap    = w_wrap;
  assign o_pid_stb = r_pid_stb;
  assign o_cnt     = r_cnt;

endmodule

// File: rtl/pwm_fan_driver.sv
// Fan PWM driver: clamps the signed PID output to a duty, runs the
// OFF/KICK/RUN spin-up state machine at each PWM wrap and drives the pin.
module pwm_fan_driver
  import pwm_fan_driver_pkg::*;
#(
  parameter int ADC_BITWIDTH = 8,
  parameter int PRESCALE     = 4,
  parameter int PID_DIV      = 16,
  parameter int KICK_PERIODS = 32,
  parameter int MIN_DUTY     = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic signed [ADC_BITWIDTH:0]   pid_val_i,
  output logic                           pwm_o,
  output logic                           clk_en_pid_o,
  output logic [ADC_BITWIDTH-1:0]        duty_o,
  output logic                           running_o
);

  localparam int                      KICK_W = $clog2(KICK_PERIODS + 1);
  localparam logic [ADC_BITWIDTH-1:0] FULL   = '1;

  logic                    w_wrap;
  logic                    w_pid_stb;
  logic [ADC_BITWIDTH-1:0] w_cnt;
  logic [ADC_BITWIDTH-1:0] w_duty_in;
  fan_state_t              r_state;
  logic [KICK_W-1:0]       r_kick;
  logic [ADC_BITWIDTH-1:0] r_eff;
  logic                    r_pwm;

  function automatic logic [ADC_BITWIDTH-1:0] clamp_pid(input logic signed [ADC_BITWIDTH:0] v);
    return v[ADC_BITWIDTH] ? '0 : v[ADC_BITWIDTH-1:0];
  endfunction

  function automatic logic [ADC_BITWIDTH-1:0] run_duty(input logic [ADC_BITWIDTH-1:0] d);
    return (d < ADC_BITWIDTH'(MIN_DUTY)) ? ADC_BITWIDTH'(MIN_DUTY) : d;
  endfunction

  pwm_timebase #(
    .CNT_W   (ADC_BITWIDTH),
    .PRESCALE(PRESCALE),
    .PID_DIV (PID_DIV)
  ) u_timebase (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_en     (en_i),
    .o_wrap   (w_wrap),
    .o_pid_stb(w_pid_stb),
    .o_cnt    (w_cnt)
  );

  assign w_duty_in = clamp_pid(pid_val_i);

  // State and effective duty only move at a wrap, using the duty sampled there.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      r_state <= ST_OFF;
      r_kick  <= '0;
      r_eff   <= '0;
    end else if (w_wrap) begin
      case (r_state)
        ST_OFF: begin
          if (w_duty_in != '0) begin
            r_state <= ST_KICK;
            r_kick  <= '0;
            r_eff   <= FULL;
          end else begin
            r_eff   <= '0;
          end
        end
        ST_KICK: begin
          if (w_duty_in == '0) begin
            r_state <= ST_OFF;
            r_eff   <= '0;
          end else if (r_kick == KICK_W'(KICK_PERIODS - 1)) begin
            r_state <= ST_RUN;
            r_eff   <= run_duty(w_duty_in);
          end else begin
            r_kick  <= r_kick + 1'b1;
            r_eff   <= FULL;
          end
        end
        ST_RUN: begin
          if (w_duty_in == '0) begin
            r_state <= ST_OFF;
            r_eff   <= '0;
          end else begin
            r_eff   <= run_duty(w_duty_in);
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_eff   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) r_pwm <= 1'b0;
    else                r_pwm <= (w_cnt < r_eff);
  end

  assign pwm_o        = r_pwm;
  assign clk_en_pid_o = w_pid_stb;
  assign duty_o       = r_eff;
  assign running_o    = (r_state != ST_OFF);

endmodule

// File: tb/tb_pwm_fan_driver.sv
// Randomized bench for pwm_fan_driver against a cycle-position reference
// model of the PWM timing and spin-up rules.
module tb_pwm_fan_driver;

  localparam int W            = 8;
  localparam int PRESCALE     = 1;
  localparam int PID_DIV      = 2;
  localparam int KICK_PERIODS = 2;
  localparam int MIN_DUTY     = 64;
  localparam int P            = (1 << W) - 1;
  localparam int PER          = P * PRESCALE;
  localparam int FULL         = (1 << W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic signed [W:0]   pid;
  logic                pwm_o;
  logic                clk_en_pid_o;
  logic [W-1:0]        duty_o;
  logic                running_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position n counts enabled clock edges since restart.
  int n;
  int mode;            // 0 off, 1 kick, 2 run
  int kick_done;
  int m_eff, m_pwm, m_stb;
  int cyc = 0;
  int last_stb = -1;

  pwm_fan_driver #(
    .ADC_BITWIDTH(W),
    .PRESCALE    (PRESCALE),
    .PID_DIV     (PID_DIV),
    .KICK_PERIODS(KICK_PERIODS),
    .MIN_DUTY    (MIN_DUTY)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .pid_val_i   (pid),
    .pwm_o       (pwm_o),
    .clk_en_pid_o(clk_en_pid_o),
    .duty_o      (duty_o),
    .running_o   (running_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge();
    int cnt_b, d, pv;
    bit wrap;
    if (rst || !en) begin
      n = 0; mode = 0; kick_done = 0;
      m_eff = 0; m_pwm = 0; m_stb = 0;
      return;
    end
    cnt_b = (n / PRESCALE) % P;
    m_pwm = (cnt_b < m_eff) ? 1 : 0;
    wrap  = ((n + 1) % PER) == 0;
    m_stb = (wrap && (((n + 1) / PER) % PID_DIV == 0)) ? 1 : 0;
    if (wrap) begin
      pv = int'(pid);
      d  = (pv < 0) ? 0 : pv;
      if (d == 0) mode = 0;
      else if (mode == 0) begin mode = 1; kick_done = 0; end
      else if (mode == 1) begin
        kick_done++;
        if (kick_done == KICK_PERIODS) mode = 2;
      end
      m_eff = (mode == 0) ? 0 : (mode == 1) ? FULL : ((d > MIN_DUTY) ? d : MIN_DUTY);
    end
    n++;
  endtask

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      check_val("pwm_o", int'(pwm_o), m_pwm);
      check_val("clk_en_pid_o", int'(clk_en_pid_o), m_stb);
      check_val("duty_o", int'(duty_o), m_eff);
      check_val("running_o", int'(running_o), (mode != 0) ? 1 : 0);
      if (rst || !en) last_stb = -1;
      else if (clk_en_pid_o) begin
        if (last_stb >= 0) check_val("strobe_gap", cyc - last_stb, PID_DIV * PER);
        last_stb = cyc;
      end
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pid = '0;
    n = 0; mode = 0; kick_done = 0; m_eff = 0; m_pwm = 0; m_stb = 0;
    step(3);
    rst = 1'b0;
    step(2);
    en = 1'b1;
    step(1100);                                  // zero demand: idle, strobes only
    pid = 9'sd100;  step(6 * PER + 37);          // kick then run at 100
    pid = 9'sd20;   step(100);
    pid = 9'sd30;   step(3 * PER);               // mid-period change, floored to MIN_DUTY
    pid = -9'sd50;  step(2 * PER);
    pid = 9'sd100;  step(4 * PER);
    pid = 9'sd255;  step(3 * PER);
    pid = 9'sd0;    step(PER);
    pid = 9'sd100;  step(300);                   // inside kick
    pulse_rst();
    step(3 * PER);
    step(200);
    en = 1'b0;      step(7);                     // disable mid-period in run
    en = 1'b1;      step(2 * PID_DIV * PER + 20);

    for (int s = 0; s < 24; s++) begin
      case ($urandom_range(0, 4))
        0:       pid = '0;
        1:       pid = (W+1)'(-int'($urandom_range(1, 256)));
        2:       pid = (W+1)'($urandom_range(1, MIN_DUTY - 1));
        3:       pid = (W+1)'($urandom_range(MIN_DUTY, FULL - 1));
        default: pid = (W+1)'(FULL);
      endcase
      case ($urandom_range(0, 7))
        0: pulse_rst();
        1: begin
          en = 1'b0;
          step($urandom_range(1, 300));
          en = 1'b1;
        end
        default: ;
      endcase
      step($urandom_range(100, 800));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
